// File: rtl/therm_pkg.sv
// Shared constants and the count clamp used by the thermometer decoder.
package therm_pkg;

  localparam int N_DEFAULT  = 32;
  localparam int CW_DEFAULT = 6;

  // Limits a requested count to the number of available output bits.
  function automatic int unsigned clamp_count(input int unsigned count, input int unsigned limit);
    return (count > limit) ? limit : count;
  endfunction

endpackage

// File: rtl/therm_expand.sv
// Combinational count-to-thermometer expansion, filling from bit 0 or from bit N-1.
module therm_expand #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic [CW-1:0] count,
  input  logic          msb,
  output logic [N-1:0]  code
);

  logic [N-1:0] fill;

  always_comb begin
    fill = '0;
    code = '0;
    for (int i = 0; i < N; i++) begin
      fill[i] = (i < int'(count));
    end
    // Downward fill is the upward pattern mirrored across the word.
    for (int i = 0; i < N; i++) begin
      code[i] = msb ? fill[N-1-i] : fill[i];
    end
  end

endmodule

// File: rtl/therm32_decoder.sv
// Two-stage valid/ready pipeline: S1 holds the clamped count, S2 holds the expanded code.
module therm32_decoder
  import therm_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [CW-1:0] in_count,
  input  logic          in_msb,
  output logic          in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_therm,
  output logic          out_sat,
  input  logic          out_ready
);

  logic          s1_valid;
  logic [CW-1:0] s1_count;
  logic          s1_msb;
  logic          s1_sat;

  logic          s2_valid;
  logic [N-1:0]  s2_therm;
  logic          s2_sat;

  logic          s1_adv;
  logic          s2_adv;
  logic [N-1:0]  code;

  assign s2_adv   = out_ready | ~s2_valid;
  assign s1_adv   = s2_adv | ~s1_valid;
  assign in_ready = s1_adv & ~rst;

  therm_expand #(
    .N  (N),
    .CW (CW)
  ) u_expand (
    .count (s1_count),
    .msb   (s1_msb),
    .code  (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_count <= '0;
      s1_msb   <= 1'b0;
      s1_sat   <= 1'b0;
      s2_valid <= 1'b0;
      s2_therm <= '0;
      s2_sat   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        s1_count <= CW'(clamp_count(32'(in_count), N));
        s1_msb   <= in_msb;
        s1_sat   <= (32'(in_count) > N);
      end
      // An empty S1 loads zeros so the output reads 0 whenever it is not valid.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        s2_therm <= s1_valid ? code : '0;
        s2_sat   <= s1_valid & s1_sat;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_therm = s2_therm;
  assign out_sat   = s2_sat;

endmodule

// File: tb/tb_therm32_decoder.sv
// Directed and scoreboarded checks for the two-stage thermometer decoder.
module tb_therm32_decoder;

  localparam int N  = 32;
  localparam int CW = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_count;
  logic          in_msb;
  logic          in_ready;
  logic          out_valid;
  logic [N-1:0]  out_therm;
  logic          out_sat;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  logic [32:0] qexp[$];
  int          src_count[$];
  bit          src_msb[$];
  int          idx;
  int          accepted;
  logic        hold_prev;
  logic [32:0] held;
  logic [32:0] e;
  int          guard;

  therm32_decoder #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_msb    (in_msb),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_therm (out_therm),
    .out_sat   (out_sat),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: shift-based masks rather than a per-bit loop.
  function automatic logic [32:0] model(input int c_in, input bit msb);
    int c;
    logic [31:0] t;
    c = (c_in > 32) ? 32 : c_in;
    if (c == 32)   t = 32'hFFFF_FFFF;
    else if (msb)  t = ~(32'hFFFF_FFFF >> c);
    else           t = (32'h1 << c) - 32'h1;
    return {(c_in > 32), t};
  endfunction

  // One cycle of streaming: drive at the negedge, settle, record transfers, advance.
  task automatic cyc(input bit ordy, input bit ivld_en);
    in_valid = ivld_en && (idx < src_count.size());
    if (idx < src_count.size()) begin
      in_count = CW'(src_count[idx]);
      in_msb   = src_msb[idx];
    end
    out_ready = ordy;
    #1;
    if (hold_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {out_sat, out_therm}, held);
    end
    if (out_valid && out_ready) begin
      chk("out_expected", qexp.size() != 0, 1);
      if (qexp.size() != 0) begin
        e = qexp.pop_front();
        chk("stream_out", {out_sat, out_therm}, e);
      end
    end
    hold_prev = out_valid && !out_ready;
    held      = {out_sat, out_therm};
    if (in_valid && in_ready) begin
      qexp.push_back(model(src_count[idx], src_msb[idx]));
      idx++;
      accepted++;
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_count  = '0;
    in_msb    = 1'b0;
    out_ready = 1'b0;
    hold_prev = 1'b0;
    held      = '0;
    idx       = 0;
    accepted  = 0;

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("rst_in_ready_low", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_therm", out_therm, 0);
    chk("post_rst_sat", out_sat, 0);

    // Count 0: all-zero code after two cycles
    in_valid = 1'b1; in_count = 6'd0; in_msb = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_not_1", out_valid, 0);
    @(negedge clk);
    chk("c0_valid", out_valid, 1);
    chk("c0_therm", out_therm, 32'h0000_0000);
    chk("c0_sat", out_sat, 0);

    // Back-to-back 1, 5, 32, 40 upward
    @(negedge clk);
    in_valid = 1'b1; in_count = 6'd1;
    @(negedge clk);
    in_count = 6'd5;
    @(negedge clk);
    in_count = 6'd32;
    chk("b2b_1_valid", out_valid, 1);
    chk("b2b_1", out_therm, 32'h0000_0001);
    @(negedge clk);
    in_count = 6'd40;
    chk("b2b_5", out_therm, 32'h0000_001F);
    chk("b2b_5_sat", out_sat, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_32", out_therm, 32'hFFFF_FFFF);
    chk("b2b_32_sat", out_sat, 0);
    @(negedge clk);
    chk("b2b_40", out_therm, 32'hFFFF_FFFF);
    chk("b2b_40_sat", out_sat, 1);
    @(negedge clk);
    chk("b2b_drained", out_valid, 0);
    chk("idle_therm_zero", out_therm, 0);

    // Count 3 downward
    in_valid = 1'b1; in_count = 6'd3; in_msb = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("msb3_valid", out_valid, 1);
    chk("msb3_therm", out_therm, 32'hE000_0000);
    chk("msb3_popcount", $countones(out_therm), 3);
    @(negedge clk);

    // Backpressure: out_ready low for 5 cycles with a continuous stream
    for (int k = 1; k <= 8; k++) begin
      src_count.push_back(2 * k);
      src_msb.push_back(1'b0);
    end
    idx = 0; accepted = 0; hold_prev = 1'b0;
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1);
    chk("bp_accepted", accepted, 2);
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    guard = 0;
    while ((idx < src_count.size() || qexp.size() != 0) && guard < 60) begin
      cyc(1'b1, 1'b1);
      guard++;
    end
    chk("bp_sent", idx, 8);
    chk("bp_drained", qexp.size(), 0);

    // Reset with both stages full discards everything
    src_count.delete(); src_msb.delete();
    src_count.push_back(10); src_msb.push_back(1'b0);
    src_count.push_back(20); src_msb.push_back(1'b1);
    src_count.push_back(30); src_msb.push_back(1'b0);
    idx = 0; hold_prev = 1'b0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    #1;
    chk("mid_full_valid", out_valid, 1);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_blocks_in_ready", in_ready, 0);
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_therm", out_therm, 0);
    chk("mid_rst_sat", out_sat, 0);
    rst = 1'b0; in_valid = 1'b0;
    qexp.delete(); hold_prev = 1'b0;
    #1;
    chk("mid_rst_release_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale_out", out_valid, 0);
    end

    // Randomised stream: all 64 counts in both directions, random gaps and backpressure
    src_count.delete(); src_msb.delete();
    for (int c = 0; c < 64; c++) begin
      src_count.push_back(c); src_msb.push_back(1'b0);
      src_count.push_back(c); src_msb.push_back(1'b1);
    end
    for (int k = src_count.size() - 1; k > 0; k--) begin
      int j;
      int tc;
      bit tm;
      j = $urandom_range(0, k);
      tc = src_count[k]; src_count[k] = src_count[j]; src_count[j] = tc;
      tm = src_msb[k];   src_msb[k]   = src_msb[j];   src_msb[j]   = tm;
    end
    idx = 0; hold_prev = 1'b0;
    guard = 0;
    while ((idx < src_count.size() || qexp.size() != 0) && guard < 3000) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      guard++;
    end
    chk("rand_sent", idx, 128);
    chk("rand_drained", qexp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/therm32_decoder.md
THERM32_DECODER -- requirements
Module: therm32_decoder

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the thermometer output width.
REQ-002 The block SHALL have parameter CW, default 6, giving the count width; CW SHALL equal clog2(N+1).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  input count is presented.
REQ-006 in_count  input  CW  number of ones to generate, from 0 to 2^CW-1.
REQ-007 in_msb  input  1  fill direction: 0 fills from bit 0 upward; 1 fills from bit N-1 downward.
REQ-008 in_ready  output  1  block accepts the input this cycle.
REQ-009 out_valid  output  1  out_therm and out_sat hold a result.
REQ-010 out_therm  output  N  thermometer code.
REQ-011 out_sat  output  1  the count was greater than N and was clamped.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-013 Input transfer SHALL occur when in_valid and in_ready are both high; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 Pipeline: stage S1 SHALL register the clamped count, the in_msb bit and the saturation flag; stage S2 SHALL register the N-bit code and the saturation flag.
REQ-015 Latency SHALL be exactly 2 cycles from input transfer to out_valid high, with no backpressure.
REQ-016 Clamp rule: c = min(in_count, N); out_sat = (in_count > N).
REQ-017 With in_msb=0, out_therm[i] SHALL be 1 iff i < c.
REQ-018 With in_msb=1, out_therm[N-1-i] SHALL be 1 iff i < c.
REQ-019 popcount(out_therm) SHALL always equal c.
REQ-020 A stage SHALL advance when it is empty or when its successor advances this cycle; S2 advances when out_ready is high or S2 is empty.
REQ-021 in_ready SHALL be high when S1 is empty or S1 advances this cycle. in_ready is combinational from out_ready; no register slice is required.
REQ-022 Throughput SHALL be one result per cycle while out_ready is held high.
REQ-023 While out_valid is high and out_ready is low, out_therm and out_sat SHALL hold stable, and no data SHALL be lost or duplicated.
REQ-024 A simultaneous input transfer and output transfer SHALL be handled in the same cycle without a bubble.
REQ-025 c=0 SHALL give an all-zero code; c=N SHALL give an all-ones code, independent of in_msb.
REQ-026 A stage that is not valid SHALL have data outputs that are don't-care internally; out_therm SHALL still read 0 when out_valid is low.

Reset
REQ-027 When rst is high on a rising clk edge, both stage valid bits, out_therm and out_sat SHALL clear to 0.
REQ-028 in_ready SHALL be high in the first cycle after rst deasserts.
REQ-029 While rst is high, in_ready SHALL be low; no transfer SHALL be recorded in that cycle.
REQ-030 Reset mid-operation SHALL discard all in-flight results without emitting them.

Structure
REQ-031 The constants N_DEFAULT=32 and CW_DEFAULT=6, and a function clamp_count, SHALL live in the shared package therm_pkg.
REQ-032 Count-to-code expansion SHALL be a purely combinational sub-module therm_expand (inputs: count, msb; output: N-bit code), instantiated once in S2.
REQ-033 Each pipeline stage SHALL be a valid/data register pair. There SHALL be no other state.
REQ-034 Expected size SHALL be 120-250 lines of RTL including the sub-module.

Verification
REQ-035 Reset then in_count=0, in_msb=0, out_ready=1 -> at cycle +2, out_valid=1, out_therm=0x00000000, out_sat=0.
REQ-036 Back-to-back inputs 1, 5, 32, 40 (msb=0), with out_ready=1 -> consecutive outputs 0x00000001, 0x0000001F, 0xFFFFFFFF, and 0xFFFFFFFF with out_sat=1.
REQ-037 in_count=3 with in_msb=1 -> out_therm=0xE0000000; popcount=3.
REQ-038 out_ready low for 5 cycles with a continuous input stream -> in_ready drops after 2 accepted inputs, outputs hold stable, and all inputs emerge in order once out_ready rises.
REQ-039 rst asserted while S1 and S2 are both valid -> next cycle out_valid=0 and in_ready=0; after release, no stale output appears.
REQ-040 Randomized stream with random out_ready -> scoreboard matches REQ-016 to REQ-019 for all 64 count values in both directions.
